// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared state type and defaults for the reaction timer
package reaction_pkg;

  // Round controller states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_TIMING = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Default reaction-count width in ms ticks
  localparam int COUNT_W_DEFAULT = 14;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchroniser with registered rising-edge pulse
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  // Two-flop synchroniser, delayed copy, and a registered one-clk press pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      press <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// rtl/reaction_timer_multi.sv - multi-player reaction timer with false-start and winner logic
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int COUNT_W = COUNT_W_DEFAULT,
  localparam int WIN_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick_ms,
  input  logic                        start,
  input  logic                        go,
  input  logic                        clear,
  input  logic [NUM_CH-1:0]           button,
  output logic [NUM_CH*COUNT_W-1:0]   reaction_time,
  output logic [NUM_CH-1:0]           time_valid,
  output logic [NUM_CH-1:0]           false_start,
  output logic [WIN_W-1:0]            winner,
  output logic                        winner_valid,
  output logic                        state_busy,
  output logic                        timeout
);

  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_LAST = {{(COUNT_W-1){1'b1}}, 1'b0};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t                           state_q, state_d;
  logic [COUNT_W-1:0]               count_q, count_d;
  logic [NUM_CH-1:0][COUNT_W-1:0]   rt_q, rt_d;
  logic [NUM_CH-1:0]                tv_q, tv_d;
  logic [NUM_CH-1:0]                fs_q, fs_d;
  logic                             timeout_q, timeout_d;
  logic                             busy_q;
  logic [WIN_W-1:0]                 win_q, win_c;
  logic                             wv_q, wv_c;
  logic [COUNT_W-1:0]               best_rt;
  logic                             results_clr;
  logic [NUM_CH-1:0]                press;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_btn
      btn_sync_edge u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (button[g]),
        .press (press[g])
      );
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next round results; clear beats start beats everything else
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rt_d        = rt_q;
    tv_d        = tv_q;
    fs_d        = fs_q;
    timeout_d   = timeout_q;
    results_clr = 1'b0;
    if (clear || start) begin
      state_d     = clear ? S_IDLE : S_ARMED;
      count_d     = '0;
      rt_d        = '0;
      tv_d        = '0;
      fs_d        = '0;
      timeout_d   = 1'b0;
      results_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_ARMED: begin
          fs_d = fs_q | press;
          if (go) state_d = S_TIMING;
        end
        S_TIMING: begin
          // Capture uses the pre-increment count, so a coincident tick is not seen
          for (int i = 0; i < NUM_CH; i++) begin
            if (press[i] && !tv_q[i] && !fs_q[i]) begin
              rt_d[i] = count_q;
              tv_d[i] = 1'b1;
            end
          end
          if (tick_ms && count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          if (tick_ms && count_q == CNT_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end else if (&(tv_d | fs_d)) begin
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Fastest valid channel from the registered results; strict compare keeps the lowest index on ties
  always_comb begin
    win_c   = '0;
    wv_c    = 1'b0;
    best_rt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tv_q[i] && (!wv_c || rt_q[i] < best_rt)) begin
        win_c   = WIN_W'(i);
        wv_c    = 1'b1;
        best_rt = rt_q[i];
      end
    end
  end

  // Result, count and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      rt_q      <= '0;
      tv_q      <= '0;
      fs_q      <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      win_q     <= '0;
      wv_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      rt_q      <= rt_d;
      tv_q      <= tv_d;
      fs_q      <= fs_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == S_ARMED) || (state_d == S_TIMING);
      win_q     <= results_clr ? '0 : win_c;
      wv_q      <= results_clr ? 1'b0 : wv_c;
    end
  end

  assign reaction_time = rt_q;
  assign time_valid    = tv_q;
  assign false_start   = fs_q;
  assign winner        = win_q;
  assign winner_valid  = wv_q;
  assign state_busy    = busy_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// tb/tb_reaction_timer_multi.sv - scoreboard bench for reaction_timer_multi
module tb_reaction_timer_multi;

  localparam int NUM_CH  = 2;
  localparam int COUNT_W = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms = 1'b0;
  logic        start = 1'b0;
  logic        go = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  button = 2'b00;
  logic [27:0] reaction_time;
  logic [1:0]  time_valid;
  logic [1:0]  false_start;
  logic        winner;
  logic        winner_valid;
  logic        state_busy;
  logic        timeout;

  always #5 clk = ~clk;

  reaction_timer_multi #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_ms       (tick_ms),
    .start         (start),
    .go            (go),
    .clear         (clear),
    .button        (button),
    .reaction_time (reaction_time),
    .time_valid    (time_valid),
    .false_start   (false_start),
    .winner        (winner),
    .winner_valid  (winner_valid),
    .state_busy    (state_busy),
    .timeout       (timeout)
  );

  typedef struct packed {
    logic [13:0] rt0;
    logic [13:0] rt1;
    logic [1:0]  tv;
    logic [1:0]  fs;
    logic        win;
    logic        wv;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One clock of stimulus: inputs change on the falling edge, sample 1 ns after the rising edge
  task automatic cyc(input logic t, input logic s, input logic g, input logic c, input logic [1:0] b);
    @(negedge clk);
    tick_ms = t;
    start   = s;
    go      = g;
    clear   = c;
    button  = b;
    @(posedge clk);
    #1;
  endtask

  // Reference: p = tick count seen at the first press, -1 = pressed before go
  function automatic exp_t model(input int p0, input int p1);
    exp_t e;
    int   p[2];
    int   best;
    p    = '{p0, p1};
    e    = '0;
    best = -1;
    for (int i = 0; i < 2; i++) begin
      if (p[i] < 0) e.fs[i] = 1'b1;
      else          e.tv[i] = 1'b1;
    end
    e.rt0 = (p0 >= 0) ? 14'(p0) : 14'd0;
    e.rt1 = (p1 >= 0) ? 14'(p1) : 14'd0;
    for (int i = 0; i < 2; i++)
      if (p[i] >= 0 && (best < 0 || p[i] < p[best])) best = i;
    e.wv  = (best >= 0);
    e.win = (best == 1);
    return e;
  endfunction

  // Monitor: a round is reported when the controller leaves ARMED/TIMING; winner settles one clk later
  always begin : monitor
    exp_t e;
    @(negedge clk);
    if (busy_prev && !state_busy) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_end: got round end, expected none queued");
      end else begin
        e = exp_q.pop_front();
        chk("rt0",          32'(reaction_time[13:0]),  32'(e.rt0));
        chk("rt1",          32'(reaction_time[27:14]), 32'(e.rt1));
        chk("time_valid",   32'(time_valid),           32'(e.tv));
        chk("false_start",  32'(false_start),          32'(e.fs));
        chk("winner",       32'(winner),               32'(e.win));
        chk("winner_valid", 32'(winner_valid),         32'(e.wv));
        chk("timeout",      32'(timeout),              32'(e.to));
        chk("busy_end",     32'(state_busy),           32'd0);
      end
    end
    busy_prev = state_busy;
  end

  // Play one round; p = tick of first press (-1 false start), r = tick of a repeat press (-1 none)
  task automatic run_round(input int p0, input int p1, input int r0, input int r1);
    logic [1:0] fsm;
    logic [1:0] m;
    int         last;
    exp_q.push_back(model(p0, p1));
    cyc(0, 1, 0, 0, 2'b00);
    fsm = {p1 < 0, p0 < 0};
    if (fsm != 2'b00) repeat (5) cyc(0, 0, 0, 0, fsm);
    cyc(0, 0, 1, 0, 2'b00);
    last = (p0 > p1) ? p0 : p1;
    for (int k = 0; k <= last; k++) begin
      m[0] = (p0 == k) || (r0 == k);
      m[1] = (p1 == k) || (r1 == k);
      if (m != 2'b00) begin
        // Press event reaches the controller on the 4th edge, together with this tick
        repeat (3) cyc(0, 0, 0, 0, m);
        cyc(1, 0, 0, 0, m);
      end else begin
        cyc(1, 0, 0, 0, 2'b00);
      end
    end
    repeat (6) cyc(0, 0, 0, 0, 2'b00);
  endtask

  initial begin
    int p0, p1, r0, r1;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rt",      32'(reaction_time), 32'd0);
    chk("rst_tv",      32'(time_valid),    32'd0);
    chk("rst_fs",      32'(false_start),   32'd0);
    chk("rst_wv",      32'(winner_valid),  32'd0);
    chk("rst_busy",    32'(state_busy),    32'd0);
    chk("rst_timeout", 32'(timeout),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 2'b00);
    cyc(0, 0, 0, 0, 2'b00);
    chk("go_in_idle", 32'(state_busy), 32'd0);

    run_round(250, 290, -1, -1);
    run_round(180, -1, -1, -1);
    run_round(200, 200, -1, -1);
    run_round(99, 200, 150, -1);
    run_round(-1, -1, 10, -1);

    for (int n = 0; n < 16; n++) begin
      p0 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 300));
      p1 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 300));
      if (p0 >= 0 && $urandom_range(0, 5) == 0) p1 = p0;
      r0 = -1;
      r1 = -1;
      if ($urandom_range(0, 2) == 0) r0 = (p0 < 0) ? int'($urandom_range(0, 60)) : p0 + int'($urandom_range(3, 60));
      if ($urandom_range(0, 2) == 0) r1 = (p1 < 0) ? int'($urandom_range(0, 60)) : p1 + int'($urandom_range(3, 60));
      run_round(p0, p1, r0, r1);
    end

    // Asynchronous reset in the middle of TIMING, between clock edges
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    repeat (5) cyc(1, 0, 0, 0, 2'b00);
    repeat (3) cyc(0, 0, 0, 0, 2'b01);
    cyc(1, 0, 0, 0, 2'b01);
    repeat (2) cyc(0, 0, 0, 0, 2'b00);
    chk("pre_rst_tv", 32'(time_valid), 32'd1);
    chk("pre_rst_rt", 32'(reaction_time[13:0]), 32'd5);
    exp_q.push_back('0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_rt",   32'(reaction_time), 32'd0);
    chk("async_rst_tv",   32'(time_valid),    32'd0);
    chk("async_rst_wv",   32'(winner_valid),  32'd0);
    chk("async_rst_busy", 32'(state_busy),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 2'b00);
    cyc(0, 0, 0, 0, 2'b00);
    chk("after_rst_go_ignored", 32'(state_busy), 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 2'b00);

    // Clear together with start while TIMING
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    repeat (3) cyc(1, 0, 0, 0, 2'b00);
    repeat (3) cyc(0, 0, 0, 0, 2'b10);
    cyc(1, 0, 0, 0, 2'b10);
    cyc(0, 0, 0, 0, 2'b00);
    chk("pre_clear_tv", 32'(time_valid), 32'd2);
    exp_q.push_back('0);
    cyc(0, 1, 0, 1, 2'b00);
    chk("clear_start_busy", 32'(state_busy), 32'd0);
    repeat (3) cyc(0, 0, 0, 0, 2'b00);
    chk("clear_start_idle", 32'(state_busy), 32'd0);
    chk("clear_start_tv",   32'(time_valid), 32'd0);

    // Saturation timeout with no presses
    exp_q.push_back(exp_t'{rt0: 14'd0, rt1: 14'd0, tv: 2'b00, fs: 2'b00, win: 1'b0, wv: 1'b0, to: 1'b1});
    cyc(0, 1, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    repeat (16382) cyc(1, 0, 0, 0, 2'b00);
    chk("pre_sat_timeout", 32'(timeout),    32'd0);
    chk("pre_sat_busy",    32'(state_busy), 32'd1);
    cyc(1, 0, 0, 0, 2'b00);
    chk("sat_timeout", 32'(timeout),    32'd1);
    chk("sat_busy",    32'(state_busy), 32'd0);
    cyc(1, 0, 0, 0, 2'b00);
    chk("extra_tick_timeout", 32'(timeout),    32'd1);
    chk("extra_tick_tv",      32'(time_valid), 32'd0);
    repeat (5) cyc(0, 0, 0, 0, 2'b11);
    repeat (2) cyc(0, 0, 0, 0, 2'b00);
    chk("done_press_tv", 32'(time_valid),    32'd0);
    chk("done_press_rt", 32'(reaction_time), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d rounds unreported, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reaction_timer_multi.md
REACTION_TIMER_MULTI -- requirements
Module: reaction_timer_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of player channels (1..8).
REQ-002 SHALL have parameter COUNT_W, default 14: reaction-count width, in ms ticks.
REQ-003 SHALL have port clk, input, 1: single system clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tick_ms, input, 1: one-clk-wide 1 ms enable pulse.
REQ-006 SHALL have port start, input, 1: one-clk pulse; arms a new round.
REQ-007 SHALL have port go, input, 1: one-clk pulse; lights out, timing begins.
REQ-008 SHALL have port clear, input, 1: one-clk pulse; abort round and clear results.
REQ-009 SHALL have port button, input, NUM_CH: raw asynchronous buttons, active-high.
REQ-010 SHALL have port reaction_time, output, NUM_CH*COUNT_W: per-channel captured count, channel i at bits [i*COUNT_W +: COUNT_W].
REQ-011 SHALL have port time_valid, output, NUM_CH: channel holds a legal reaction time.
REQ-012 SHALL have port false_start, output, NUM_CH: channel pressed before go.
REQ-013 SHALL have port winner, output, $clog2(NUM_CH) (min 1): index of the fastest valid channel.
REQ-014 SHALL have port winner_valid, output, 1: winner is meaningful.
REQ-015 SHALL have port state_busy, output, 1: high in ARMED or TIMING.
REQ-016 SHALL have port timeout, output, 1: count saturated before all channels finished.

Function
REQ-017 SHALL pass each button through a 2-flop synchroniser, then a rising-edge detector; a press event is asserted one clk, 3 clk edges after the raw input rises.
REQ-018 SHALL implement FSM IDLE, ARMED, TIMING, DONE; reset state IDLE.
REQ-019 SHALL transition IDLE->ARMED and DONE->ARMED on start, clearing all result outputs and the count in the same edge.
REQ-020 SHALL transition ARMED->TIMING on go; go in IDLE, TIMING or DONE SHALL be ignored.
REQ-021 SHALL, in ARMED, set false_start[i] on a press event on channel i; that channel is finished for the round.
REQ-022 SHALL, in TIMING, increment the count by 1 on each tick_ms, saturating at 2^COUNT_W-1 (no wrap).
REQ-023 SHALL, in TIMING, on the first press event of an unfinished channel i, load reaction_time[i] with the pre-increment count and set time_valid[i].
REQ-024 SHALL ignore repeat presses on a finished channel, and all presses in IDLE and DONE.
REQ-025 SHALL compute winner as the valid channel with the smallest reaction_time; ties go to the lowest index; winner_valid=0 while no channel is valid.
REQ-026 SHALL transition TIMING->DONE when every channel is finished.
REQ-027 SHALL transition TIMING->DONE on the tick_ms that reaches saturation; it SHALL set timeout and leave unfinished channels with time_valid=0 and reaction_time=0.
REQ-028 SHALL, on clear in any state, go to IDLE and zero all outputs; clear takes priority over start and go in the same cycle.
REQ-029 SHALL treat start in ARMED or TIMING as a restart to ARMED with results cleared.
REQ-030 SHALL make a press event and tick_ms in the same cycle capture the pre-increment value.
REQ-031 SHALL register all outputs; winner/winner_valid SHALL update one clk after the capturing edge.

Reset
REQ-032 SHALL force state IDLE and zero count, reaction_time, time_valid, false_start, winner, winner_valid, timeout and the synchroniser/edge flops on rst, asynchronously, regardless of clk.
REQ-033 SHALL leave a round aborted by reset with no residual result; the next round needs start.

Structure
REQ-034 SHALL place the FSM state enum typedef and the default COUNT_W constant in shared package reaction_pkg.
REQ-035 SHALL use one sub-module, btn_sync_edge (synchroniser + rising-edge detect, clk/rst), instantiated NUM_CH times via generate.

Verification (NUM_CH=2, COUNT_W=14)
REQ-036 SHALL check: start, go, 250 ticks, press ch0; 40 more ticks, press ch1 -> rt0=250, rt1=290, time_valid=2'b11, winner=0, state DONE.
REQ-037 SHALL check: start, press ch1 before go, go, press ch0 after 180 ticks -> false_start=2'b10, rt0=180, time_valid=2'b01, winner=0, DONE.
REQ-038 SHALL check: both presses on the same edge after 200 ticks -> rt0=rt1=200, winner=0 (tie to lowest index).
REQ-039 SHALL check: start, go, no presses, 16383 ticks -> count holds 16383, timeout=1, time_valid=0, DONE; an extra tick makes no change.
REQ-040 SHALL check: press coincident with tick_ms at count 99 -> rt=99; repeat press -> rt unchanged.
REQ-041 SHALL check: rst asserted mid-TIMING between clk edges -> outputs zero immediately; clear together with start -> IDLE.
